z8_memory_controller: RTL and testbench
=======================================

Name: z8_memory_controller

Overview:
- Parametrised data/program memory controller for the z8 processor core.
- Adds registered, handshaked data access; a hardware clear sweep after reset; a program-memory load port for boot/test loading; and a registered instruction fetch.
- Sits between core execute/writeback stages and on-chip RAMs.
- Op encodings MEM_READ and MEM_WRITE come from the instruction_set package. Any other op value is a no-op.

Parameters:
- DATA_W, 16, data word width
- DATA_DEPTH, 256, data memory words (power of two)
- INSTR_W, 40, instruction word width
- PROG_DEPTH, 256, program memory words (power of two)
- ADDR_W, 16, width of addr, pc, prog_addr ports

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- op  in  2  memory op (MEM_READ / MEM_WRITE / other = none)
- req  in  1  op qualifier; op ignored when 0
- addr  in  ADDR_W  data address
- write_data  in  DATA_W  store data
- ready  out  1  controller accepts req this cycle
- read_data  out  DATA_W  load result
- read_valid  out  1  read_data valid, one-cycle pulse
- busy  out  1  clear sweep in progress
- fault  out  1  out-of-range access pulse (optional feature only; tied 0 otherwise)
- pc  in  ADDR_W  fetch address
- current_instruction  out  INSTR_W  fetched instruction
- instr_valid  out  1  current_instruction valid
- prog_we  in  1  program memory write enable
- prog_addr  in  ADDR_W  program write address
- prog_wdata  in  INSTR_W  program write data

Behaviour:
- Reset (sampled high at posedge):
  - Outputs: read_data=0, read_valid=0, current_instruction=0, instr_valid=0, fault=0, ready=0, busy=1.
  - FSM enters CLEAR with clear_cnt=0.
  - Program memory is not cleared.
- FSM states CLEAR and IDLE.
  - CLEAR: writes 0 to data_mem[clear_cnt] each cycle and increments clear_cnt; ready=0, busy=1. Exits to IDLE on the cycle writing DATA_DEPTH-1, so CLEAR lasts exactly DATA_DEPTH cycles after reset deasserts.
  - IDLE: ready=1, busy=0.
  - Reset asserted mid-CLEAR restarts the sweep at 0.
- Handshake: an access is accepted when req && ready at posedge. req while ready=0 is dropped, not queued; the core must hold req until ready.
- Write (MEM_WRITE accepted):
  - data_mem[addr] <= write_data at that edge; no read_valid.
  - A read accepted in the next cycle at the same address returns the new data.
- Read (MEM_READ accepted): latency 1.
  - read_data <= data_mem[addr] at the accept edge; read_valid=1 for the following cycle only.
  - read_data holds its last value when read_valid=0.
  - Back-to-back reads are allowed every cycle (throughput 1/cycle).
- Address mapping: data index = addr[log2(DATA_DEPTH)-1:0]; upper bits are ignored, so addresses wrap modulo DATA_DEPTH.
- Fetch:
  - Each cycle out of reset: current_instruction <= prog_mem[pc index], 1-cycle latency.
  - instr_valid=1 from the first edge after reset deasserts. Fetch runs during CLEAR.
  - pc is indexed modulo PROG_DEPTH.
- Program load:
  - prog_we writes prog_mem[prog_addr index] <= prog_wdata; allowed in any state, including CLEAR.
  - Same-cycle fetch of the same index returns the OLD word (read-before-write); the new word is visible from the next fetch.
- Simultaneous data write and program write are independent and both complete.

Optional Feature:
- Macro: Z8_MEM_BOUNDS_CHECK_EN.
- Defined: an accepted access with addr >= DATA_DEPTH is not performed.
  - Write is dropped.
  - Read returns read_data=0 with read_valid=1.
  - fault=1 for one cycle, aligned with the would-be read_valid cycle; for writes, the cycle after accept.
  - pc >= PROG_DEPTH fetches all-zero (NOP) and also pulses fault.
- Undefined: modulo wrap as above; fault is tied to 0.

Test Plan:
- Reset 1 cycle, then hold req=1 with op=MEM_READ, addr=0 -> ready=0 and busy=1 for 256 cycles; first read accepted on cycle 257; read_data=0x0000 with read_valid pulse.
- Write 0xBEEF to addr 0x0012, then read 0x0012 the next cycle -> read_valid the following cycle with read_data=0xBEEF. Read 0x0112 -> 0xBEEF via wrap (macro off), or read_data=0 with fault=1 (macro on).
- Reads to 0x01, 0x02, 0x03 on consecutive cycles after writing 0x1111/0x2222/0x3333 -> read_valid high 3 consecutive cycles with data in order.
- prog_we with prog_addr=5, prog_wdata=0x12_3456_789A while pc=5 -> current_instruction shows the old word next cycle and 0x123456789A the cycle after.
- Reset asserted at clear_cnt=100 -> sweep restarts; ready rises exactly 256 cycles after reset deasserts; a location written before reset reads 0.
- op=2'b11 with req=1 in IDLE -> no memory change, no read_valid, no fault.

Source files
------------

// File: rtl/z8_memory_controller_if.sv
// Data-access bus between the z8 core and its memory controller.
// The master side issues ops; the slave side (the controller) answers them.
interface z8_memory_controller_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [1:0]        op;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              ready;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              busy;
    logic              fault;

    modport master (
        output op, req, addr, write_data,
        input  ready, read_data, read_valid, busy, fault
    );

    modport slave (
        input  op, req, addr, write_data,
        output ready, read_data, read_valid, busy, fault
    );
endinterface

// File: rtl/z8_memory_controller.sv
// z8 data/program memory controller: post-reset clear sweep, handshaked data access,
// program load port and registered fetch. Z8_MEM_BOUNDS_CHECK_EN enables range faults.
package instruction_set;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;
endpackage

module z8_memory_controller #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DATA_DEPTH = 256,
    parameter int unsigned INSTR_W    = 40,
    parameter int unsigned PROG_DEPTH = 256,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    z8_memory_controller_if.slave bus,
    input  logic [ADDR_W-1:0]    pc,
    output logic [INSTR_W-1:0]   current_instruction,
    output logic                 instr_valid,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0]   prog_wdata
);
    import instruction_set::*;

    localparam int unsigned DIDX_W = $clog2(DATA_DEPTH);
    localparam int unsigned PIDX_W = $clog2(PROG_DEPTH);
    localparam logic [DIDX_W-1:0] CLEAR_LAST = DIDX_W'(DATA_DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state, state_next;
    logic [DIDX_W-1:0]   clear_cnt, clear_next;

    logic [DATA_W-1:0]   data_mem [DATA_DEPTH];
    logic [INSTR_W-1:0]  prog_mem [PROG_DEPTH];

    logic [DIDX_W-1:0]   data_idx;
    logic [PIDX_W-1:0]   pc_idx, prog_idx;
    logic                accept, rd_accept, wr_accept;
    logic                addr_oob, pc_oob;
    logic                mem_we;
    logic [DIDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]   mem_wdata;
    logic                unused_bits;

    assign data_idx = bus.addr[DIDX_W-1:0];
    assign pc_idx   = pc[PIDX_W-1:0];
    assign prog_idx = prog_addr[PIDX_W-1:0];

    // Upper address bits only matter when range checking is built in.
    assign unused_bits = ^{bus.addr, pc, prog_addr};

`ifdef Z8_MEM_BOUNDS_CHECK_EN
    assign addr_oob = ({1'b0, bus.addr} >= (ADDR_W + 1)'(DATA_DEPTH));
    assign pc_oob   = ({1'b0, pc} >= (ADDR_W + 1)'(PROG_DEPTH));
`else
    assign addr_oob = 1'b0;
    assign pc_oob   = 1'b0;
`endif

    assign bus.ready = (state == IDLE);
    assign bus.busy  = (state == CLEAR);

    assign accept    = bus.req && bus.ready && !reset;
    assign rd_accept = accept && (bus.op == MEM_READ);
    assign wr_accept = accept && (bus.op == MEM_WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR;
            clear_cnt <= '0;
        end else begin
            state     <= state_next;
            clear_cnt <= clear_next;
        end
    end

    // The clear sweep and accepted writes share the single data-memory write port.
    always_comb begin
        state_next = state;
        clear_next = clear_cnt;
        mem_we     = 1'b0;
        mem_idx    = data_idx;
        mem_wdata  = bus.write_data;
        case (state)
            CLEAR: begin
                mem_we     = 1'b1;
                mem_idx    = clear_cnt;
                mem_wdata  = '0;
                clear_next = clear_cnt + 1'b1;
                if (clear_cnt == CLEAR_LAST) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                mem_we = wr_accept && !addr_oob;
            end
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            data_mem[mem_idx] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.read_data  <= '0;
            bus.read_valid <= 1'b0;
        end else begin
            bus.read_valid <= rd_accept;
            if (rd_accept) begin
                bus.read_data <= addr_oob ? '0 : data_mem[data_idx];
            end
        end
    end

`ifdef Z8_MEM_BOUNDS_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= ((rd_accept || wr_accept) && addr_oob) || pc_oob;
        end
    end

    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (prog_we) begin
            prog_mem[prog_idx] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            current_instruction <= '0;
            instr_valid         <= 1'b0;
        end else begin
            current_instruction <= pc_oob ? '0 : prog_mem[pc_idx];
            instr_valid         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_z8_memory_controller.sv
// Scoreboard bench for z8_memory_controller: expected read results are queued at issue
// and compared when read_valid appears.
`timescale 1ns/1ps
module tb_z8_memory_controller;
    import instruction_set::*;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned INSTR_W = 40;
`ifdef Z8_MEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              fault;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] current_instruction;
    logic               instr_valid;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_wdata;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   rv_count = 0;
    int   rv_run   = 0;

    z8_memory_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    z8_memory_controller #(
        .DATA_W(DATA_W),
        .DATA_DEPTH(256),
        .INSTR_W(INSTR_W),
        .PROG_DEPTH(256),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .pc(pc),
        .current_instruction(current_instruction),
        .instr_valid(instr_valid),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_wdata(prog_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.read_valid === 1'b1) begin
            rv_count++;
            rv_run++;
            if (sb.size() == 0) begin
                check("rv_unexpected", 64'(bus.read_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check("read_data", 64'(bus.read_data), 64'(e.data));
                check("read_fault", 64'(bus.fault), 64'(e.fault));
            end
        end else begin
            rv_run = 0;
        end
    end

    // Called at a negedge; returns at the next negedge after the accepting posedge.
    task automatic issue(input logic [1:0] o, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd);
        exp_t e;
        check("ready_at_issue", 64'(bus.ready), 64'd1);
        bus.req        = 1'b1;
        bus.op         = o;
        bus.addr       = a;
        bus.write_data = wd;
        if (o == MEM_READ) begin
            if (BOUNDS && a >= 16'd256) begin
                e.data  = '0;
                e.fault = 1'b1;
            end else begin
                e.data  = exp_rd;
                e.fault = 1'b0;
            end
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req = 1'b0;
        bus.op  = 2'b00;
    endtask

    task automatic wait_ready(output int n, output int busy_bad);
        n        = 0;
        busy_bad = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            if (bus.busy !== 1'b1) busy_bad++;
            n++;
            @(negedge clk);
        end
    endtask

    localparam logic [INSTR_W-1:0] P_OLD = 40'hA5_0000_0005;
    localparam logic [INSTR_W-1:0] P_NEW = 40'h12_3456_789A;
    localparam logic [INSTR_W-1:0] P7    = 40'h0F_0F0F_0F07;

    initial begin
        int n, bb, rv_before;
        reset          = 1'b1;
        bus.req        = 1'b0;
        bus.op         = 2'b00;
        bus.addr       = '0;
        bus.write_data = '0;
        pc             = '0;
        prog_we        = 1'b0;
        prog_addr      = '0;
        prog_wdata     = '0;
        @(negedge clk);

        check("rst_read_data", 64'(bus.read_data), 64'd0);
        check("rst_read_valid", 64'(bus.read_valid), 64'd0);
        check("rst_instr", 64'(current_instruction), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_fault", 64'(bus.fault), 64'd0);
        check("rst_ready", 64'(bus.ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd1);

        // Read held during the sweep must be dropped until ready rises.
        reset   = 1'b0;
        bus.req = 1'b1;
        bus.op  = MEM_READ;
        bus.addr = '0;
        wait_ready(n, bb);
        check("clear_len", 64'(n), 64'd256);
        check("busy_during_clear", 64'(bb), 64'd0);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("instr_valid_run", 64'(instr_valid), 64'd1);
        issue(MEM_READ, 16'h0000, '0, 16'h0000);

        issue(MEM_WRITE, 16'h0012, 16'hBEEF, '0);
        issue(MEM_READ, 16'h0012, '0, 16'hBEEF);
        issue(MEM_READ, 16'h0112, '0, 16'hBEEF);

        issue(MEM_WRITE, 16'h0001, 16'h1111, '0);
        issue(MEM_WRITE, 16'h0002, 16'h2222, '0);
        issue(MEM_WRITE, 16'h0003, 16'h3333, '0);
        rv_before = rv_count;
        issue(MEM_READ, 16'h0001, '0, 16'h1111);
        issue(MEM_READ, 16'h0002, '0, 16'h2222);
        issue(MEM_READ, 16'h0003, '0, 16'h3333);
        idle();
        #1;
        check("b2b_run", 64'(rv_run), 64'd3);
        check("b2b_count", 64'(rv_count - rv_before), 64'd3);
        @(negedge clk);

        // Illegal/no-op encodings leave memory untouched and raise nothing.
        issue(MEM_WRITE, 16'h0020, 16'h7777, '0);
        rv_before = rv_count;
        issue(2'b11, 16'h0020, 16'h9999, '0);
        check("noop_fault", 64'(bus.fault), 64'd0);
        issue(2'b00, 16'h0020, 16'h9999, '0);
        check("noop_fault2", 64'(bus.fault), 64'd0);
        idle();
        @(negedge clk);
        #1;
        check("noop_no_rv", 64'(rv_count - rv_before), 64'd0);
        issue(MEM_READ, 16'h0020, '0, 16'h7777);
        idle();

        // Program load with read-before-write, plus a concurrent data write.
        pc         = 16'd0;
        prog_we    = 1'b1;
        prog_addr  = 16'd5;
        prog_wdata = P_OLD;
        @(negedge clk);
        pc             = 16'd5;
        prog_wdata     = P_NEW;
        bus.req        = 1'b1;
        bus.op         = MEM_WRITE;
        bus.addr       = 16'h0030;
        bus.write_data = 16'hC3C3;
        @(negedge clk);
        prog_we = 1'b0;
        idle();
        check("fetch_old", 64'(current_instruction), 64'(P_OLD));
        @(negedge clk);
        check("fetch_new", 64'(current_instruction), 64'(P_NEW));
        check("fetch_valid", 64'(instr_valid), 64'd1);
        issue(MEM_READ, 16'h0030, '0, 16'hC3C3);

        issue(MEM_WRITE, 16'h0040, 16'h5A5A, '0);
        issue(MEM_READ, 16'h0040, '0, 16'h5A5A);
        idle();
        repeat (2) @(negedge clk);

        // Restart the sweep part-way through; program load runs during CLEAR.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 0) begin
                prog_we    = 1'b1;
                prog_addr  = 16'd7;
                prog_wdata = P7;
                pc         = 16'd7;
            end
            if (i == 1) prog_we = 1'b0;
            if (i == 3) check("fetch_in_clear", 64'(current_instruction), 64'(P7));
            @(negedge clk);
        end
        check("busy_mid_clear", 64'(bus.busy), 64'd1);
        check("ready_mid_clear", 64'(bus.ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready(n, bb);
        check("clear_len_restart", 64'(n), 64'd256);
        check("busy_restart", 64'(bb), 64'd0);
        issue(MEM_READ, 16'h0040, '0, 16'h0000);
        issue(MEM_READ, 16'h0012, '0, 16'h0000);
        idle();
        repeat (3) @(negedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
